confirm_input_ctrl: RTL and testbench
=====================================

Name: confirm_input_ctrl

Overview:
Controller for the memory-mapped switch-input path. It synchronizes and debounces the raw confirm button and latches a sticky confirmation flag that the CPU polls at 0xFFFF_FF00. It freezes a snapshot of the 16 switches at the accepted press and generates the read-enable (switch_ctrl) for the switch-input register.
It sits between the board pins, the CPU MMIO read decode and the switch-input register.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive stable synchronized cycles needed to accept a press or release (board build overrides to 200000); legal range 1..2^CNT_W-1.
CNT_W, 18, debounce counter width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-low
btn_raw  input  1  raw confirm button, asynchronous, bouncy, active-high
sw_raw  input  16  raw switch levels, asynchronous
io_read  input  1  CPU MMIO read strobe, one cycle per load
address  input  32  CPU MMIO address
switch_ctrl  output  1  read-enable to the switch-input register
confirmation  output  1  sticky pending-press flag to the switch-input register
switch_data  output  16  switch value presented to the switch-input register
overrun  output  1  sticky: a press was accepted while one was already pending

Behaviour:
- Reset: when rst=0 at a clock edge, all state clears. confirmation=0, overrun=0, switch_ctrl=0, switch_data=0, FSM=IDLE, counter=0, synchronizers=0.
- Synchronizer: btn_raw and sw_raw each pass through 2 flops (btn_s, sw_s). All logic uses only the synchronized values.
- Debounce FSM:
  - IDLE: btn_s=1 -> go to DB_PRESS, counter=1.
  - DB_PRESS: btn_s=0 -> go to IDLE, counter=0. btn_s=1 with counter=DEBOUNCE_CYCLES -> press accepted, go to HELD. Otherwise counter+1.
  - HELD: btn_s=0 -> go to DB_RELEASE, counter=1.
  - DB_RELEASE: btn_s=1 -> go to HELD. btn_s=0 with counter=DEBOUNCE_CYCLES -> go to IDLE. Otherwise counter+1.
  - The counter never wraps.
- Press accepted when confirmation=0: confirmation<=1 and snapshot<=sw_s on the same edge.
- Press accepted when confirmation=1: overrun<=1; snapshot is unchanged.
- Latency: clean btn_raw rising before edge k gives confirmation=1 after edge k+DEBOUNCE_CYCLES+2.
- One held press produces exactly one acceptance; holding the button never re-triggers.
- Clear: io_read=1 and address=0xFFFF_FF00 clears confirmation and overrun at that edge. The switch-input register samples the pre-edge value, so the CPU reads 1 exactly once.
- Simultaneous clear and accepted press: set wins. confirmation stays 1, the snapshot updates and overrun is unchanged.
- switch_data is registered:
  - confirmation=1 -> switch_data=snapshot.
  - confirmation=0 -> switch_data=sw_s (live).
- switch_ctrl is combinational: io_read AND address in {FFFF_FF00, FFFF_FFF1, FFFF_FFF3, FFFF_FFF5, FFFF_FFF7, FFFF_FFF9}. Any other address gives 0.
- Reset mid-debounce or mid-hold: returns to IDLE. A still-held button must then re-debounce fully before it is accepted.

Test Plan:
- Reset, then btn_raw=1 steady with DEBOUNCE_CYCLES=20 -> confirmation rises after exactly 22 edges; overrun=0.
- Bounce: btn_raw toggles every 5 cycles for 60 cycles, then returns to 0 -> confirmation stays 0 throughout.
- sw_raw=0x00A5, then a press; sw_raw changes to 0xFFFF while pending -> switch_data=0x00A5. Then read 0xFFFF_FF00 -> confirmation=0 next cycle, and switch_data=0xFFFF two cycles later.
- Press, full release, second press without a clear -> overrun=1, snapshot holds the first value. A read of FF00 clears both flags.
- Clear read on the same edge as an acceptance -> confirmation=1 afterwards, snapshot updated.
- io_read=1 at 0xFFFF_FFF3 -> switch_ctrl=1; at 0xFFFF_FFF2 or with io_read=0 -> switch_ctrl=0. rst=0 mid-DB_PRESS -> all outputs 0, full re-debounce required.

Source files
------------

// File: rtl/confirm_input_ctrl.sv
// ============================================================================
// confirm_input_ctrl: debounced confirm button, sticky confirm/overrun flags,
// switch snapshot and switch-register read enable for the MMIO input path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module confirm_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int CNT_W           = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_raw,
   input  logic [15:0] sw_raw,
   input  logic        io_read,
   input  logic [31:0] address,
   output logic        switch_ctrl,
   output logic        confirmation,
   output logic [15:0] switch_data,
   output logic        overrun
);

   localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [31:0]      CONF_ADDR = 32'hFFFF_FF00;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_meta_q, btn_meta_d;
   logic             btn_s_q, btn_s_d;
   logic [15:0]      sw_meta_q, sw_meta_d;
   logic [15:0]      sw_s_q, sw_s_d;
   logic             conf_q, conf_d;
   logic             overrun_q, overrun_d;
   logic [15:0]      snap_q, snap_d;
   logic [15:0]      sw_data_q, sw_data_d;
   logic             accept;
   logic             clear;

   assign clear = io_read && (address == CONF_ADDR);

   // Only one of these addresses belongs to the confirm flag; the rest are
   // other views of the same switch-input register.
   assign switch_ctrl = io_read && ((address == CONF_ADDR)     ||
                                    (address == 32'hFFFF_FFF1) ||
                                    (address == 32'hFFFF_FFF3) ||
                                    (address == 32'hFFFF_FFF5) ||
                                    (address == 32'hFFFF_FFF7) ||
                                    (address == 32'hFFFF_FFF9));

   always_comb begin
      btn_meta_d = btn_raw;
      btn_s_d    = btn_meta_q;
      sw_meta_d  = sw_raw;
      sw_s_d     = sw_meta_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;

      case (state_q)
         IDLE: begin
            if (btn_s_q) begin
               state_d = DB_PRESS;
               cnt_d   = CNT_ONE;
            end
         end
         DB_PRESS: begin
            if (!btn_s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LIMIT) begin
               state_d = HELD;
               cnt_d   = '0;
               accept  = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!btn_s_q) begin
               state_d = DB_RELEASE;
               cnt_d   = CNT_ONE;
            end
         end
         DB_RELEASE: begin
            if (btn_s_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LIMIT) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      conf_d    = conf_q;
      overrun_d = overrun_q;
      snap_d    = snap_q;

      // A clear coinciding with an acceptance is treated as consumed by the
      // new press: the flag stays set, the snapshot refreshes, overrun holds.
      if (accept && (clear || !conf_q)) begin
         conf_d = 1'b1;
         snap_d = sw_s_q;
      end else if (accept) begin
         overrun_d = 1'b1;
      end else if (clear) begin
         conf_d    = 1'b0;
         overrun_d = 1'b0;
      end

      sw_data_d = conf_q ? snap_q : sw_s_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         btn_meta_q <= 1'b0;
         btn_s_q    <= 1'b0;
         sw_meta_q  <= '0;
         sw_s_q     <= '0;
         conf_q     <= 1'b0;
         overrun_q  <= 1'b0;
         snap_q     <= '0;
         sw_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         btn_meta_q <= btn_meta_d;
         btn_s_q    <= btn_s_d;
         sw_meta_q  <= sw_meta_d;
         sw_s_q     <= sw_s_d;
         conf_q     <= conf_d;
         overrun_q  <= overrun_d;
         snap_q     <= snap_d;
         sw_data_q  <= sw_data_d;
      end
   end

   assign confirmation = conf_q;
   assign overrun      = overrun_q;
   assign switch_data  = sw_data_q;

endmodule

`default_nettype wire

// File: tb/tb_confirm_input_ctrl.sv
// ============================================================================
// tb_confirm_input_ctrl: directed self-checking bench for confirm_input_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_confirm_input_ctrl;

   localparam int DB = 20;

   logic        clk;
   logic        rst;
   logic        btn_raw;
   logic [15:0] sw_raw;
   logic        io_read;
   logic [31:0] address;
   logic        switch_ctrl;
   logic        confirmation;
   logic [15:0] switch_data;
   logic        overrun;

   int n_cmp;
   int n_err;

   confirm_input_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (18)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_raw      (btn_raw),
      .sw_raw       (sw_raw),
      .io_read      (io_read),
      .address      (address),
      .switch_ctrl  (switch_ctrl),
      .confirmation (confirmation),
      .switch_data  (switch_data),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic release_btn();
      btn_raw = 1'b0;
      repeat (DB + 8) tick();
   endtask

   task automatic clear_read();
      io_read = 1'b1;
      address = 32'hFFFF_FF00;
      tick();
      io_read = 1'b0;
      address = 32'h0;
   endtask

   task automatic test_reset();
      sw_raw  = 16'h1234;
      btn_raw = 1'b0;
      rst     = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (confirmation !== 1'b0) begin
         n_err++;
         $display("FAIL reset_conf: got %b expected 0", confirmation);
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL reset_overrun: got %b expected 0", overrun);
      end
      n_cmp++;
      if (switch_data !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_swdata: got %h expected 0000", switch_data);
      end
      n_cmp++;
      if (switch_ctrl !== 1'b0) begin
         n_err++;
         $display("FAIL reset_swctrl: got %b expected 0", switch_ctrl);
      end
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (switch_data !== 16'h1234) begin
         n_err++;
         $display("FAIL reset_live_sw: got %h expected 1234", switch_data);
      end
   endtask

   task automatic test_latency();
      do_reset();
      repeat (3) tick();
      btn_raw = 1'b1;
      for (int i = 1; i <= DB + 2; i++) begin
         tick();
         n_cmp++;
         if (confirmation !== 1'b0) begin
            n_err++;
            $display("FAIL lat_early edge %0d: got %b expected 0", i, confirmation);
         end
      end
      tick();
      n_cmp++;
      if (confirmation !== 1'b1) begin
         n_err++;
         $display("FAIL lat_rise: got %b expected 1", confirmation);
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL lat_overrun: got %b expected 0", overrun);
      end
      repeat (3 * DB) tick();
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL hold_no_retrigger: overrun got %b expected 0", overrun);
      end
      release_btn();
   endtask

   task automatic test_bounce();
      do_reset();
      for (int i = 0; i < 60; i++) begin
         btn_raw = ((i / 5) % 2 == 0);
         tick();
         n_cmp++;
         if (confirmation !== 1'b0) begin
            n_err++;
            $display("FAIL bounce cycle %0d: got %b expected 0", i, confirmation);
         end
      end
      release_btn();
      n_cmp++;
      if (confirmation !== 1'b0 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL bounce_end: conf=%b ovr=%b expected 0 0", confirmation, overrun);
      end
   endtask

   task automatic test_snapshot();
      do_reset();
      sw_raw = 16'h00A5;
      repeat (3) tick();
      btn_raw = 1'b1;
      repeat (DB + 3) tick();
      n_cmp++;
      if (confirmation !== 1'b1) begin
         n_err++;
         $display("FAIL snap_conf: got %b expected 1", confirmation);
      end
      sw_raw = 16'hFFFF;
      repeat (4) tick();
      n_cmp++;
      if (switch_data !== 16'h00A5) begin
         n_err++;
         $display("FAIL snap_hold: got %h expected 00a5", switch_data);
      end
      clear_read();
      n_cmp++;
      if (confirmation !== 1'b0) begin
         n_err++;
         $display("FAIL snap_clear: got %b expected 0", confirmation);
      end
      n_cmp++;
      if (switch_data !== 16'h00A5) begin
         n_err++;
         $display("FAIL snap_one_after: got %h expected 00a5", switch_data);
      end
      tick();
      n_cmp++;
      if (switch_data !== 16'hFFFF) begin
         n_err++;
         $display("FAIL snap_live: got %h expected ffff", switch_data);
      end
      repeat (2 * DB) tick();
      n_cmp++;
      if (confirmation !== 1'b0) begin
         n_err++;
         $display("FAIL snap_held_no_retrigger: got %b expected 0", confirmation);
      end
      release_btn();
   endtask

   task automatic test_overrun();
      do_reset();
      sw_raw = 16'h1111;
      repeat (3) tick();
      btn_raw = 1'b1;
      repeat (DB + 3) tick();
      release_btn();
      sw_raw  = 16'h2222;
      btn_raw = 1'b1;
      repeat (DB + 3) tick();
      n_cmp++;
      if (overrun !== 1'b1 || confirmation !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_set: conf=%b ovr=%b expected 1 1", confirmation, overrun);
      end
      tick();
      n_cmp++;
      if (switch_data !== 16'h1111) begin
         n_err++;
         $display("FAIL ovr_snap: got %h expected 1111", switch_data);
      end
      clear_read();
      n_cmp++;
      if (overrun !== 1'b0 || confirmation !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_clear: conf=%b ovr=%b expected 0 0", confirmation, overrun);
      end
      release_btn();
   endtask

   task automatic test_simul_clear();
      do_reset();
      sw_raw = 16'h3333;
      repeat (3) tick();
      btn_raw = 1'b1;
      repeat (DB + 3) tick();
      release_btn();
      sw_raw = 16'h4444;
      repeat (3) tick();
      btn_raw = 1'b1;
      repeat (DB + 2) tick();
      clear_read();
      n_cmp++;
      if (confirmation !== 1'b1) begin
         n_err++;
         $display("FAIL simul_conf: got %b expected 1", confirmation);
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL simul_overrun: got %b expected 0", overrun);
      end
      tick();
      n_cmp++;
      if (switch_data !== 16'h4444) begin
         n_err++;
         $display("FAIL simul_snap: got %h expected 4444", switch_data);
      end
      release_btn();
      clear_read();
   endtask

   task automatic test_switch_ctrl();
      logic [31:0] good [6];
      good = '{32'hFFFF_FF00, 32'hFFFF_FFF1, 32'hFFFF_FFF3,
               32'hFFFF_FFF5, 32'hFFFF_FFF7, 32'hFFFF_FFF9};
      for (int i = 0; i < 6; i++) begin
         io_read = 1'b1;
         address = good[i];
         #1;
         n_cmp++;
         if (switch_ctrl !== 1'b1) begin
            n_err++;
            $display("FAIL swctrl_hit %h: got %b expected 1", good[i], switch_ctrl);
         end
         io_read = 1'b0;
         #1;
         n_cmp++;
         if (switch_ctrl !== 1'b0) begin
            n_err++;
            $display("FAIL swctrl_noread %h: got %b expected 0", good[i], switch_ctrl);
         end
         tick();
      end
      io_read = 1'b1;
      address = 32'hFFFF_FFF2;
      #1;
      n_cmp++;
      if (switch_ctrl !== 1'b0) begin
         n_err++;
         $display("FAIL swctrl_fff2: got %b expected 0", switch_ctrl);
      end
      address = 32'hFFFF_FF01;
      #1;
      n_cmp++;
      if (switch_ctrl !== 1'b0) begin
         n_err++;
         $display("FAIL swctrl_ff01: got %b expected 0", switch_ctrl);
      end
      io_read = 1'b0;
      address = 32'h0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      sw_raw = 16'h5A5A;
      repeat (3) tick();
      btn_raw = 1'b1;
      repeat (12) tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if (confirmation !== 1'b0 || overrun !== 1'b0 || switch_data !== 16'h0000 ||
          switch_ctrl !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_outputs: conf=%b ovr=%b data=%h ctrl=%b expected 0 0 0000 0",
                  confirmation, overrun, switch_data, switch_ctrl);
      end
      rst = 1'b1;
      for (int i = 1; i <= DB + 2; i++) begin
         tick();
         n_cmp++;
         if (confirmation !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_early edge %0d: got %b expected 0", i, confirmation);
         end
      end
      tick();
      n_cmp++;
      if (confirmation !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_accept: got %b expected 1", confirmation);
      end
      release_btn();
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      btn_raw = 1'b0;
      sw_raw  = 16'h0;
      io_read = 1'b0;
      address = 32'h0;
      tick();
      test_reset();
      test_latency();
      test_bounce();
      test_snapshot();
      test_overrun();
      test_simul_clear();
      test_switch_ctrl();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
